// File: rtl/piano_key_encoder.sv
// rtl/piano_key_encoder.sv - debounced 7-key to 3-bit note encoder
// Commits a note only after the candidate has held steady, with a forced silent gap between notes.
module piano_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] keys_raw,
  output logic [2:0] note_sw,
  output logic       note_strobe,
  output logic       release_strobe,
  output logic       multi_key
);

  typedef enum logic {S_IDLE, S_HELD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [6:0]       sync1, sync2;
  logic [2:0]       cand, ref_code;
  logic             cmulti, rmulti;
  logic [2:0]       nkeys;
  logic [CNT_W-1:0] cnt;
  logic             match, stable, cnt_clr;
  logic [2:0]       note_nxt;
  logic             note_strobe_nxt, release_strobe_nxt, multi_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys_raw;
      sync2 <= sync1;
    end
  end

  // A chord collapses to code 0 so it can never be committed as a note.
  always_comb begin
    cand   = '0;
    cmulti = 1'b0;
    nkeys  = '0;
    for (int i = 0; i < 7; i++) begin
      if (sync2[i]) begin
        nkeys = nkeys + 3'd1;
        cand  = 3'(i + 1);
      end
    end
    if (nkeys > 3'd1) begin
      cand   = '0;
      cmulti = 1'b1;
    end
  end

  assign match  = (cand == ref_code) && (cmulti == rmulti);
  assign stable = match && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_code <= '0;
      rmulti   <= 1'b0;
      cnt      <= '0;
    end else if (!match) begin
      ref_code <= cand;
      rmulti   <= cmulti;
      cnt      <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (stable && ref_code != 3'd0) state_nxt = S_HELD;
      S_HELD:  if (stable && ref_code != note_sw) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Leaving a note restarts the count, so silence must itself hold a full debounce window.
  always_comb begin
    note_nxt           = note_sw;
    note_strobe_nxt    = 1'b0;
    release_strobe_nxt = 1'b0;
    multi_nxt          = multi_key;
    cnt_clr            = 1'b0;
    case (state)
      S_IDLE: begin
        if (stable) begin
          if (ref_code != 3'd0) begin
            note_nxt        = ref_code;
            note_strobe_nxt = 1'b1;
          end else begin
            multi_nxt = rmulti;
          end
        end
      end
      S_HELD: begin
        if (stable && ref_code != note_sw) begin
          note_nxt           = 3'd0;
          release_strobe_nxt = 1'b1;
          multi_nxt          = rmulti;
          cnt_clr            = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      note_sw        <= '0;
      note_strobe    <= 1'b0;
      release_strobe <= 1'b0;
      multi_key      <= 1'b0;
    end else begin
      note_sw        <= note_nxt;
      note_strobe    <= note_strobe_nxt;
      release_strobe <= release_strobe_nxt;
      multi_key      <= multi_nxt;
    end
  end

endmodule

// File: tb/tb_piano_key_encoder.sv
// tb/tb_piano_key_encoder.sv - scoreboard bench for piano_key_encoder
// A window-based reference model queues expected output events; a monitor pops and compares them.
module tb_piano_key_encoder;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] keys_raw = '0;
  logic [2:0] note_sw;
  logic       note_strobe, release_strobe, multi_key;

  piano_key_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .keys_raw(keys_raw), .note_sw(note_sw),
    .note_strobe(note_strobe), .release_strobe(release_strobe), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int t; int kind; int note; int multi;} ev_t;
  ev_t expq[$];

  bit [6:0] kh [0:8191];
  int       ch [0:8191];
  int       m_note = 0, m_multi = 0, m_lc = 0;
  int       n_vec = 0, n_bad = 0;

  // Candidate code: 0 none, 1..7 single key, 8 chord.
  function automatic int decode(input bit [6:0] k);
    int n = 0;
    int code = 0;
    for (int i = 0; i < 7; i++) if (k[i]) begin n++; code = i + 1; end
    if (n == 0) return 0;
    if (n == 1) return code;
    return 8;
  endfunction

  function automatic void push(input int t, input int kind, input int note, input int multi);
    ev_t e;
    e.t = t; e.kind = kind; e.note = note; e.multi = multi;
    expq.push_back(e);
  endfunction

  // Drive one cycle and predict the upcoming edge: a decision happens when the candidate
  // seen two edges after sampling has been identical for D+1 edges and at least D edges
  // have passed since the last release or reset.
  task automatic step(input bit [6:0] k, input bit r);
    int t;
    bit stable;
    int code, m;
    @(negedge clk);
    keys_raw = k;
    reset = r;
    t = cyc + 1;
    if (r) begin
      kh[t] = '0;
      if (t > 0) kh[t-1] = '0;
      ch[t] = 0;
      m_note = 0; m_multi = 0; m_lc = t;
      return;
    end
    kh[t] = k;
    ch[t] = (t >= 2) ? decode(kh[t-2]) : 0;
    stable = (t - m_lc >= D);
    if (stable) for (int i = 1; i <= D; i++) if (ch[t-i] != ch[t]) stable = 1'b0;
    if (!stable) return;
    code = ch[t] & 7;
    m = ch[t] >> 3;
    if (m_note == 0) begin
      if (code != 0) begin
        m_note = code;
        push(t, 1, code, m_multi);
      end else if (m != m_multi) begin
        m_multi = m;
        push(t, 3, 0, m);
      end
    end else if (code != m_note) begin
      m_note = 0; m_multi = m; m_lc = t;
      push(t, 2, 0, m);
    end
  endtask

  task automatic hold(input bit [6:0] k, input int n);
    repeat (n) step(k, 1'b0);
  endtask

  int cur_note = 0, prev_multi = 0;

  always begin
    ev_t e;
    int ka;
    @(posedge clk);
    #1;
    while (expq.size() > 0 && expq[0].t < cyc) begin
      n_vec++; n_bad++;
      $display("FAIL missed_event expected kind %0d at cycle %0d, now cycle %0d", expq[0].kind, expq[0].t, cyc);
      e = expq.pop_front();
      cur_note = e.note; prev_multi = e.multi;
    end
    if (reset) begin
      n_vec++;
      if (note_sw != 0 || note_strobe || release_strobe || multi_key) begin
        n_bad++;
        $display("FAIL reset_state cycle %0d got note=%0d ns=%0b rs=%0b mk=%0b want all 0", cyc, note_sw, note_strobe, release_strobe, multi_key);
      end
      cur_note = 0; prev_multi = 0;
    end else if (note_strobe || release_strobe || (int'(multi_key) != prev_multi)) begin
      ka = note_strobe ? 1 : (release_strobe ? 2 : 3);
      n_vec++;
      if (note_strobe && release_strobe) begin
        n_bad++;
        $display("FAIL strobe_overlap cycle %0d both strobes high, want at most one", cyc);
      end
      if (expq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cycle %0d got kind %0d note=%0d mk=%0b, want no event", cyc, ka, note_sw, multi_key);
        cur_note = note_sw; prev_multi = multi_key;
      end else begin
        e = expq.pop_front();
        if (e.t != cyc || e.kind != ka || e.note != int'(note_sw) || e.multi != int'(multi_key)) begin
          n_bad++;
          $display("FAIL event cycle %0d kind %0d note=%0d mk=%0b, want cycle %0d kind %0d note=%0d mk=%0d",
                   cyc, ka, note_sw, multi_key, e.t, e.kind, e.note, e.multi);
        end
        cur_note = e.note; prev_multi = e.multi;
      end
    end else begin
      n_vec++;
      if (int'(note_sw) != cur_note) begin
        n_bad++;
        $display("FAIL note_level cycle %0d got %0d want %0d", cyc, note_sw, cur_note);
      end
    end
  end

  initial begin
    bit [6:0] k;
    int r;
    step(0, 1); step(0, 1);
    hold(0, 10);
    // press key 2, release
    hold(7'b0000100, 12);
    hold(0, 12);
    // bouncing key 0
    repeat (5) begin hold(7'b0000001, 2); hold(0, 2); end
    hold(7'b0000001, 12);
    hold(0, 12);
    // slide key 2 -> key 5
    hold(7'b0000100, 12);
    hold(7'b0100000, 16);
    hold(0, 12);
    // chord from idle, then release
    hold(7'b0010010, 12);
    hold(0, 12);
    // reset while key 6 held
    hold(7'b1000000, 12);
    step(7'b1000000, 1);
    hold(7'b1000000, 12);
    hold(0, 12);
    // random patterns and lengths
    k = '0;
    repeat (300) begin
      r = $urandom_range(0, 9);
      if (r <= 2) k = '0;
      else if (r <= 7) k = 7'(1 << $urandom_range(0, 6));
      else if (r == 8) begin
        k = 7'($urandom_range(0, 127));
        while (decode(k) != 8) k = 7'($urandom_range(0, 127));
      end else step(k, 1);
      hold(k, $urandom_range(1, 10));
    end
    hold(0, 20);
    @(posedge clk);
    #2;
    n_vec++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_events got %0d pending want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
